// File: rtl/move_sequencer.sv
// move_sequencer
// Sequences one 2048 move over the 4x4 board. A single external
// combinational row-merge unit is time-shared over the four lanes, one lane
// per cycle (L0..L3). CHK then records whether the board changed. SPN drops
// a 2 or 4 into the first empty cell found by a pseudo-random circular scan.
// DONE pulses `done` and publishes `moved` / `board_full`.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   load_valid        write load_board into the board (IDLE only; beats a move)
//   load_board        cell (r,c) at bits [(4r+c)*TILE_W +: TILE_W]
//   move_valid        move request, accepted when move_ready is high
//   move_dir          0=left 1=right 2=up 3=down, sampled only at acceptance
//   move_ready        IDLE and no load pending
//   ru_a..ru_d        lane sent to the row unit (d = edge tiles slide toward)
//   ru_a_r..ru_d_r    merged lane returned by the row unit in the same cycle
//   board             current board, same packing as load_board
//   busy              high in every state except IDLE
//   done              one-cycle pulse at move completion
//   moved             last completed move changed the board
//   board_full        no empty cell (updated at load and at done)
module move_sequencer #(
    parameter int unsigned TILE_W    = 11,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_valid,
    input  logic [16*TILE_W-1:0]    load_board,
    input  logic                    move_valid,
    input  logic [1:0]              move_dir,
    output logic                    move_ready,
    output logic [TILE_W-1:0]       ru_a,
    output logic [TILE_W-1:0]       ru_b,
    output logic [TILE_W-1:0]       ru_c,
    output logic [TILE_W-1:0]       ru_d,
    input  logic [TILE_W-1:0]       ru_a_r,
    input  logic [TILE_W-1:0]       ru_b_r,
    input  logic [TILE_W-1:0]       ru_c_r,
    input  logic [TILE_W-1:0]       ru_d_r,
    output logic [16*TILE_W-1:0]    board,
    output logic                    busy,
    output logic                    done,
    output logic                    moved,
    output logic                    board_full
);

    localparam int unsigned BW = 16 * TILE_W;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        L0   = 3'd1,
        L1   = 3'd2,
        L2   = 3'd3,
        L3   = 3'd4,
        CHK  = 3'd5,
        SPN  = 3'd6,
        DONE = 3'd7
    } state_t;

    // Board index of lane position `pos` (0=d edge .. 3=a far end) in `lane`.
    // Right/down mirror the position so that d always sits at the edge
    // the tiles slide toward.
    function automatic logic [3:0] cell_idx(input logic [1:0] dir,
                                            input logic [1:0] lane,
                                            input logic [1:0] pos);
        logic [3:0] idx;
        case (dir)
            2'd0:    idx = {lane, pos};
            2'd1:    idx = {lane, ~pos};
            2'd2:    idx = {pos, lane};
            2'd3:    idx = {~pos, lane};
            default: idx = 4'd0;
        endcase
        return idx;
    endfunction

    // True when at least one cell of the packed board is zero.
    function automatic logic has_zero(input logic [BW-1:0] b);
        logic z;
        z = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (b[i*TILE_W +: TILE_W] == {TILE_W{1'b0}}) begin
                z = 1'b1;
            end else begin
                z = z;
            end
        end
        return z;
    endfunction

    // One step of the 16-bit Galois LFSR (taps 16'hB400).
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        logic [15:0] s;
        s = {1'b0, v[15:1]};
        if (v[0]) begin
            s = s ^ 16'hB400;
        end else begin
            s = s;
        end
        return s;
    endfunction

    state_t             state_q, state_d;
    logic [BW-1:0]      board_q, board_d;
    logic [BW-1:0]      snap_q,  snap_d;
    logic [1:0]         dir_q,   dir_d;
    logic               chg_q,   chg_d;
    logic               moved_q, moved_d;
    logic               full_q,  full_d;
    logic [15:0]        lfsr_q,  lfsr_d;
    logic               busy_q,  busy_d;
    logic               done_q,  done_d;

    logic [TILE_W-1:0]  cell_s [16];
    logic [1:0]         lane_s;
    logic               lane_act_s;
    logic [3:0]         idx_s [4];
    logic               spawn_found_s;
    logic [3:0]         spawn_idx_s;
    logic [TILE_W-1:0]  spawn_val_s;

    // Unpacked view of the board for indexed reads.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            cell_s[i] = board_q[i*TILE_W +: TILE_W];
        end
    end

    // Lane number and activity decoded from the lane states.
    always_comb begin
        lane_s     = 2'd0;
        lane_act_s = 1'b1;
        case (state_q)
            L0:      lane_s = 2'd0;
            L1:      lane_s = 2'd1;
            L2:      lane_s = 2'd2;
            L3:      lane_s = 2'd3;
            default: lane_act_s = 1'b0;
        endcase
    end

    // Board cells feeding lane positions d, c, b, a for the latched direction.
    always_comb begin
        for (int p = 0; p < 4; p++) begin
            idx_s[p] = cell_idx(dir_q, lane_s, 2'(p));
        end
    end

    // Row-unit drive; idle lanes are held at zero.
    always_comb begin
        ru_d = {TILE_W{1'b0}};
        ru_c = {TILE_W{1'b0}};
        ru_b = {TILE_W{1'b0}};
        ru_a = {TILE_W{1'b0}};
        if (lane_act_s) begin
            ru_d = cell_s[idx_s[0]];
            ru_c = cell_s[idx_s[1]];
            ru_b = cell_s[idx_s[2]];
            ru_a = cell_s[idx_s[3]];
        end else begin
            ru_d = {TILE_W{1'b0}};
            ru_c = {TILE_W{1'b0}};
            ru_b = {TILE_W{1'b0}};
            ru_a = {TILE_W{1'b0}};
        end
    end

    // Circular scan from lfsr[3:0] for the first empty cell; the 4-bit
    // index wraps 15 -> 0 naturally.
    always_comb begin
        logic [3:0] scan_idx;
        scan_idx      = 4'd0;
        spawn_found_s = 1'b0;
        spawn_idx_s   = 4'd0;
        for (int i = 0; i < 16; i++) begin
            scan_idx = lfsr_q[3:0] + 4'(i);
            if (!spawn_found_s && (cell_s[scan_idx] == {TILE_W{1'b0}})) begin
                spawn_found_s = 1'b1;
                spawn_idx_s   = scan_idx;
            end else begin
                spawn_found_s = spawn_found_s;
            end
        end
    end

    // Spawn value: 4 with probability 1/16, else 2.
    always_comb begin
        if (lfsr_q[7:4] == 4'hF) begin
            spawn_val_s = {{(TILE_W-3){1'b0}}, 3'd4};
        end else begin
            spawn_val_s = {{(TILE_W-3){1'b0}}, 3'd2};
        end
    end

    // Next-state and datapath update for the move sequence.
    always_comb begin
        state_d = state_q;
        board_d = board_q;
        snap_d  = snap_q;
        dir_d   = dir_q;
        chg_d   = chg_q;
        moved_d = moved_q;
        full_d  = full_q;
        lfsr_d  = lfsr_step(lfsr_q);
        case (state_q)
            IDLE: begin
                // Load wins over a same-cycle move.
                if (load_valid) begin
                    board_d = load_board;
                    full_d  = ~has_zero(load_board);
                    moved_d = 1'b0;
                end else if (move_valid) begin
                    dir_d   = move_dir;
                    snap_d  = board_q;
                    state_d = L0;
                end else begin
                    state_d = IDLE;
                end
            end
            L0, L1, L2, L3: begin
                // Results are stored exactly as the row unit returns them.
                board_d[int'(idx_s[0])*TILE_W +: TILE_W] = ru_d_r;
                board_d[int'(idx_s[1])*TILE_W +: TILE_W] = ru_c_r;
                board_d[int'(idx_s[2])*TILE_W +: TILE_W] = ru_b_r;
                board_d[int'(idx_s[3])*TILE_W +: TILE_W] = ru_a_r;
                case (state_q)
                    L0:      state_d = L1;
                    L1:      state_d = L2;
                    L2:      state_d = L3;
                    default: state_d = CHK;
                endcase
            end
            CHK: begin
                chg_d   = (board_q != snap_q);
                state_d = SPN;
            end
            SPN: begin
                if (chg_q && spawn_found_s) begin
                    board_d[int'(spawn_idx_s)*TILE_W +: TILE_W] = spawn_val_s;
                end else begin
                    board_d = board_q;
                end
                state_d = DONE;
            end
            DONE: begin
                moved_d = chg_q;
                full_d  = ~has_zero(board_q);
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            board_q <= {BW{1'b0}};
            snap_q  <= {BW{1'b0}};
            dir_q   <= 2'd0;
            chg_q   <= 1'b0;
            moved_q <= 1'b0;
            full_q  <= 1'b0;
            lfsr_q  <= LFSR_SEED;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            board_q <= board_d;
            snap_q  <= snap_d;
            dir_q   <= dir_d;
            chg_q   <= chg_d;
            moved_q <= moved_d;
            full_q  <= full_d;
            lfsr_q  <= lfsr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign move_ready = (state_q == IDLE) && !load_valid;
    assign board      = board_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign moved      = moved_q;
    assign board_full = full_q;

endmodule

// File: tb/tb_move_sequencer.sv
module tb_move_sequencer;

    localparam int          TW   = 11;
    localparam int          BW   = 16 * TW;
    localparam logic [15:0] SEED = 16'hACE1;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_valid;
    logic [BW-1:0] load_board;
    logic          move_valid;
    logic [1:0]    move_dir;
    logic          move_ready;
    logic [TW-1:0] ru_a, ru_b, ru_c, ru_d;
    logic [TW-1:0] ru_a_r, ru_b_r, ru_c_r, ru_d_r;
    logic [BW-1:0] board;
    logic          busy, done, moved, board_full;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    logic [15:0] lfsr_m;

    move_sequencer #(.TILE_W(TW), .LFSR_SEED(SEED)) dut (
        .clk(clk), .rst(rst),
        .load_valid(load_valid), .load_board(load_board),
        .move_valid(move_valid), .move_dir(move_dir), .move_ready(move_ready),
        .ru_a(ru_a), .ru_b(ru_b), .ru_c(ru_c), .ru_d(ru_d),
        .ru_a_r(ru_a_r), .ru_b_r(ru_b_r), .ru_c_r(ru_c_r), .ru_d_r(ru_d_r),
        .board(board), .busy(busy), .done(done), .moved(moved),
        .board_full(board_full)
    );

    always #5 clk = ~clk;

    // Golden 2048 row merge: slide toward d, each tile merges at most once.
    function automatic logic [4*TW-1:0] row_merge(input logic [TW-1:0] a, input logic [TW-1:0] b,
                                                  input logic [TW-1:0] c, input logic [TW-1:0] d);
        logic [TW-1:0] v [4];
        logic [TW-1:0] t [4];
        logic [TW-1:0] o [4];
        int n, i, k;
        v[0] = d; v[1] = c; v[2] = b; v[3] = a;
        for (int j = 0; j < 4; j++) begin
            t[j] = '0;
            o[j] = '0;
        end
        n = 0;
        for (int j = 0; j < 4; j++) begin
            if (v[j] != 11'd0) begin
                t[n] = v[j];
                n++;
            end
        end
        i = 0;
        k = 0;
        while (i < n) begin
            if ((i + 1 < n) && (t[i] == t[i+1])) begin
                o[k] = t[i] + t[i];
                i += 2;
            end else begin
                o[k] = t[i];
                i += 1;
            end
            k++;
        end
        return {o[3], o[2], o[1], o[0]};
    endfunction

    assign {ru_a_r, ru_b_r, ru_c_r, ru_d_r} = row_merge(ru_a, ru_b, ru_c, ru_d);

    function automatic logic [BW-1:0] put(input logic [BW-1:0] b, input int idx, input logic [TW-1:0] v);
        logic [BW-1:0] r;
        r = b;
        r[idx*TW +: TW] = v;
        return r;
    endfunction

    function automatic logic [15:0] lstep(input logic [15:0] v);
        return v[0] ? ({1'b0, v[15:1]} ^ 16'hB400) : {1'b0, v[15:1]};
    endfunction

    function automatic logic [15:0] ladv(input logic [15:0] v, input int n);
        logic [15:0] r;
        r = v;
        for (int i = 0; i < n; i++) r = lstep(r);
        return r;
    endfunction

    // Expected board after a spawn with LFSR value l at SPN.
    function automatic logic [BW-1:0] spawn_expect(input logic [BW-1:0] pre, input logic [15:0] l);
        logic [BW-1:0] r;
        logic [3:0] idx;
        logic hit;
        r = pre;
        hit = 1'b0;
        for (int i = 0; i < 16; i++) begin
            idx = l[3:0] + 4'(i);
            if (!hit && (pre[int'(idx)*TW +: TW] == 11'd0)) begin
                r[int'(idx)*TW +: TW] = (l[7:4] == 4'hF) ? 11'd4 : 11'd2;
                hit = 1'b1;
            end
        end
        return r;
    endfunction

    // Reference LFSR, advancing every cycle like the DUT's.
    always @(posedge clk) lfsr_m <= rst ? SEED : lstep(lfsr_m);

    always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic do_load(input logic [BW-1:0] b);
        load_valid = 1'b1;
        load_board = b;
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    // Called at a negedge in IDLE; returns at the negedge of cycle T+1.
    task automatic start_move(input logic [1:0] dir, output logic [15:0] l6);
        move_valid = 1'b1;
        move_dir   = dir;
        l6 = ladv(lfsr_m, 6);
        @(negedge clk);
        move_valid = 1'b0;
        move_dir   = ~dir;
    endtask

    task automatic test_reset();
        rst = 1'b1; load_valid = 1'b0; move_valid = 1'b0; move_dir = 2'd0; load_board = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        total++; if (board !== '0) begin bad++; $display("FAIL rst_board: got %h want 0", board); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", done); end
        total++; if (moved !== 1'b0) begin bad++; $display("FAIL rst_moved: got %b want 0", moved); end
        total++; if (board_full !== 1'b0) begin bad++; $display("FAIL rst_full: got %b want 0", board_full); end
        total++; if (move_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", move_ready); end
    endtask

    task automatic test_basic_left();
        logic [BW-1:0] b, pre, exp;
        logic [15:0] l6;
        b   = put(put(put('0, 0, 11'd2), 1, 11'd2), 2, 11'd4);
        pre = put(put('0, 0, 11'd4), 1, 11'd4);
        do_load(b);
        start_move(2'd0, l6);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL left_busy: got %b want 1", busy); end
        @(negedge clk);
        total++; if (board !== pre) begin bad++; $display("FAIL left_lane0: got %h want %h", board, pre); end
        repeat (4) @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL left_done_early: got %b want 0", done); end
        @(negedge clk);
        exp = spawn_expect(pre, l6);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL left_done: got %b want 1", done); end
        total++; if (board !== exp) begin bad++; $display("FAIL left_board: got %h want %h", board, exp); end
        @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL left_done_pulse: got %b want 0", done); end
        total++; if (moved !== 1'b1) begin bad++; $display("FAIL left_moved: got %b want 1", moved); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL left_busy_end: got %b want 0", busy); end
        total++; if (move_ready !== 1'b1) begin bad++; $display("FAIL left_ready: got %b want 1", move_ready); end
        total++; if (board_full !== 1'b0) begin bad++; $display("FAIL left_full: got %b want 0", board_full); end
    endtask

    task automatic test_load_priority();
        logic [BW-1:0] b, pre, exp;
        logic [15:0] l6;
        int cnt0;
        b   = put(put(put('0, 0, 11'd2), 1, 11'd2), 2, 11'd4);
        pre = put(put('0, 0, 11'd4), 1, 11'd4);
        load_valid = 1'b1; load_board = b; move_valid = 1'b1; move_dir = 2'd0;
        #1;
        total++; if (move_ready !== 1'b0) begin bad++; $display("FAIL prio_ready: got %b want 0", move_ready); end
        @(negedge clk);
        load_valid = 1'b0; move_valid = 1'b0;
        total++; if (board !== b) begin bad++; $display("FAIL prio_board: got %h want %h", board, b); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL prio_busy: got %b want 0", busy); end
        total++; if (moved !== 1'b0) begin bad++; $display("FAIL prio_moved_clr: got %b want 0", moved); end
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL prio_busy2: got %b want 0", busy); end
        cnt0 = done_cnt;
        start_move(2'd0, l6);
        move_valid = 1'b1; move_dir = 2'd1;
        repeat (4) @(negedge clk);
        move_valid = 1'b0;
        repeat (2) @(negedge clk);
        exp = spawn_expect(pre, l6);
        total++; if (board !== exp) begin bad++; $display("FAIL busy_ignore_board: got %h want %h", board, exp); end
        repeat (6) @(negedge clk);
        total++; if (done_cnt - cnt0 !== 1) begin bad++; $display("FAIL busy_ignore_dones: got %0d want 1", done_cnt - cnt0); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL busy_ignore_idle: got %b want 0", busy); end
    endtask

    task automatic test_no_change();
        logic [BW-1:0] b;
        logic [15:0] l6;
        b = '0;
        for (int r = 0; r < 4; r++) begin
            b = put(put(put(put(b, 4*r, 11'd2), 4*r+1, 11'd4), 4*r+2, 11'd8), 4*r+3, 11'd16);
        end
        do_load(b);
        total++; if (board_full !== 1'b1) begin bad++; $display("FAIL nochg_full_load: got %b want 1", board_full); end
        start_move(2'd0, l6);
        repeat (6) @(negedge clk);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL nochg_done: got %b want 1", done); end
        total++; if (board !== b) begin bad++; $display("FAIL nochg_board: got %h want %h", board, b); end
        @(negedge clk);
        total++; if (moved !== 1'b0) begin bad++; $display("FAIL nochg_moved: got %b want 0", moved); end
        total++; if (board_full !== 1'b1) begin bad++; $display("FAIL nochg_full: got %b want 1", board_full); end
    endtask

    task automatic test_up_down();
        logic [BW-1:0] b, exp;
        logic [15:0] l6;
        b = put(put(put(put('0, 1, 11'd2), 5, 11'd2), 9, 11'd2), 13, 11'd2);
        do_load(b);
        start_move(2'd2, l6);
        @(negedge clk);
        total++; if (ru_d !== 11'd2) begin bad++; $display("FAIL up_ru_d: got %0d want 2", ru_d); end
        repeat (5) @(negedge clk);
        exp = spawn_expect(put(put('0, 1, 11'd4), 5, 11'd4), l6);
        total++; if (board !== exp) begin bad++; $display("FAIL up_board: got %h want %h", board, exp); end
        @(negedge clk);
        total++; if (moved !== 1'b1) begin bad++; $display("FAIL up_moved: got %b want 1", moved); end
        do_load(b);
        start_move(2'd3, l6);
        @(negedge clk);
        total++; if (ru_d !== 11'd2) begin bad++; $display("FAIL down_ru_d: got %0d want 2", ru_d); end
        repeat (5) @(negedge clk);
        exp = spawn_expect(put(put('0, 13, 11'd4), 9, 11'd4), l6);
        total++; if (board !== exp) begin bad++; $display("FAIL down_board: got %h want %h", board, exp); end
        @(negedge clk);
    endtask

    // Distinct values 1..16 make every lane position identifiable.
    task automatic test_lane_map();
        logic [BW-1:0] b;
        logic [15:0] l6;
        int e [4];
        b = '0;
        for (int i = 0; i < 16; i++) b = put(b, i, 11'(i + 1));
        for (int dir = 0; dir < 4; dir++) begin
            do_load(b);
            start_move(2'(dir), l6);
            for (int k = 0; k < 4; k++) begin
                for (int p = 0; p < 4; p++) begin
                    case (dir)
                        0:       e[p] = 4*k + p + 1;
                        1:       e[p] = 4*k + (3 - p) + 1;
                        2:       e[p] = 4*p + k + 1;
                        default: e[p] = 4*(3 - p) + k + 1;
                    endcase
                end
                total++; if (ru_d !== 11'(e[0])) begin bad++; $display("FAIL map_d dir%0d lane%0d: got %0d want %0d", dir, k, ru_d, e[0]); end
                total++; if (ru_c !== 11'(e[1])) begin bad++; $display("FAIL map_c dir%0d lane%0d: got %0d want %0d", dir, k, ru_c, e[1]); end
                total++; if (ru_b !== 11'(e[2])) begin bad++; $display("FAIL map_b dir%0d lane%0d: got %0d want %0d", dir, k, ru_b, e[2]); end
                total++; if (ru_a !== 11'(e[3])) begin bad++; $display("FAIL map_a dir%0d lane%0d: got %0d want %0d", dir, k, ru_a, e[3]); end
                @(negedge clk);
            end
            total++; if ({ru_a, ru_b, ru_c, ru_d} !== 44'd0) begin bad++; $display("FAIL map_idle_ru dir%0d: got %h want 0", dir, {ru_a, ru_b, ru_c, ru_d}); end
            repeat (2) @(negedge clk);
            total++; if (board !== b) begin bad++; $display("FAIL map_board dir%0d: got %h want %h", dir, board, b); end
            @(negedge clk);
            total++; if (moved !== 1'b0) begin bad++; $display("FAIL map_moved dir%0d: got %b want 0", dir, moved); end
        end
    endtask

    // Time the move so lfsr[7:0]==8'hFF at SPN: scan starts at 15, value 4.
    task automatic test_wrap();
        logic [BW-1:0] b, exp;
        logic [15:0] l6;
        int tries;
        b   = put(put('0, 12, 11'd2), 13, 11'd2);
        exp = put(put('0, 15, 11'd4), 0, 11'd4);
        do_load(b);
        tries = 0;
        l6 = ladv(lfsr_m, 6);
        while ((l6[7:0] != 8'hFF) && (tries < 20000)) begin
            @(negedge clk);
            tries++;
            l6 = ladv(lfsr_m, 6);
        end
        total++;
        if (l6[7:0] !== 8'hFF) begin
            bad++; $display("FAIL wrap_timing: got %h want ff", l6[7:0]);
        end else begin
            start_move(2'd1, l6);
            repeat (6) @(negedge clk);
            total++; if (done !== 1'b1) begin bad++; $display("FAIL wrap_done: got %b want 1", done); end
            total++; if (board !== exp) begin bad++; $display("FAIL wrap_board: got %h want %h", board, exp); end
            @(negedge clk);
            total++; if (moved !== 1'b1) begin bad++; $display("FAIL wrap_moved: got %b want 1", moved); end
        end
    endtask

    task automatic test_reset_mid_move();
        logic [BW-1:0] b;
        logic [15:0] l6;
        int cnt0;
        b = put(put(put('0, 0, 11'd2), 1, 11'd2), 2, 11'd4);
        do_load(b);
        start_move(2'd0, l6);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        cnt0 = done_cnt;
        @(negedge clk);
        rst = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
        total++; if (board !== '0) begin bad++; $display("FAIL midrst_board: got %h want 0", board); end
        total++; if (move_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready: got %b want 1", move_ready); end
        total++; if (moved !== 1'b0) begin bad++; $display("FAIL midrst_moved: got %b want 0", moved); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL midrst_done: got %b want 0", done); end
        repeat (10) @(negedge clk);
        total++; if (done_cnt !== cnt0) begin bad++; $display("FAIL midrst_no_done: got %0d want %0d", done_cnt, cnt0); end
    endtask

    initial begin
        test_reset();
        test_basic_left();
        test_load_priority();
        test_no_change();
        test_up_down();
        test_lane_map();
        test_wrap();
        test_reset_mid_move();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/move_sequencer.md
# move_sequencer

Sequences one 2048 move across the 4x4 board by time-sharing a single combinational row-merge unit over the four lanes, one lane per cycle. After the four lanes it detects whether the board changed, then spawns a new tile in a pseudo-random empty cell. It owns the board register and sits between the game-input decoder (direction commands) and the display/score logic (board readout, done/moved/full flags).

## Interface
- TILE_W, 11, tile value width; board width is 16*TILE_W.
- LFSR_SEED, 16'hACE1, reset value of the spawn LFSR; must be nonzero.

- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- load_valid  in  1  load `load_board` into the board register.
- load_board  in  16*TILE_W  cell (r,c) at bits [(4r+c)*TILE_W +: TILE_W]; r=0 is top row, c=0 is left column.
- move_valid  in  1  move request.
- move_dir  in  2  0=left, 1=right, 2=up, 3=down.
- move_ready  out  1  `(state==IDLE) && !load_valid`.
- ru_a, ru_b, ru_c, ru_d  out  TILE_W each  lane presented to the row-merge unit; d is the edge that tiles slide toward.
- ru_a_r, ru_b_r, ru_c_r, ru_d_r  in  TILE_W each  merged lane returned combinationally, same cycle.
- board  out  16*TILE_W  current board, same packing as `load_board`.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at move completion.
- moved  out  1  the last completed move changed the board; held until the next done or load.
- board_full  out  1  no zero cell on the board; updated at load and at done.

## Operation
- **States:** IDLE, L0, L1, L2, L3, CHK, SPN, DONE.
- **Accepting a move:** in IDLE, `move_valid && move_ready` does three things:
  - latches `move_dir`;
  - copies the board into snapshot register `snap`;
  - moves the state to L0.
- **Load:** in IDLE, `load_valid` writes the board, recomputes `board_full` and clears `moved`. Load has priority over move: a move in the same cycle is not accepted. `load_valid` outside IDLE is ignored.
- **Lane k (state Lk):** drives `ru_*` from the board and, at the cycle end, writes `ru_*_r` back to the same cells. Cell mapping for lane k, in the order d, c, b, a:
  - left: (k,0), (k,1), (k,2), (k,3)
  - right: (k,3), (k,2), (k,1), (k,0)
  - up: (0,k), (1,k), (2,k), (3,k)
  - down: (3,k), (2,k), (1,k), (0,k)
- **Outside L0..L3,** `ru_*` are driven to 0.
- **CHK:** registers `chg = (board != snap)`.
- **SPN:**
  - If `chg` is set and at least one zero cell exists: scan indices s, s+1, … (mod 16), where s = `lfsr[3:0]`, and write the spawn value into the first zero cell.
  - Spawn value is 4 if `lfsr[7:4]==4'hF`, else 2.
  - If `chg` is 0, the board is untouched.
- **DONE:** `done`=1; `moved` <= `chg`; `board_full` recomputed from the final board. Next state is IDLE.
- **LFSR:** 16-bit Galois with mask 16'hB400. It advances every cycle, including IDLE. Reset value is LFSR_SEED.
- **Arithmetic:** the sequencer performs no arithmetic on tile values. Merging and any overflow are the row unit's responsibility, and results are stored as returned.

## Timing
- **Move latency:** a move accepted in cycle T occupies L0..L3 in T+1..T+4, CHK in T+5, SPN in T+6 and DONE in T+7. `done`=1 in T+7 only. `move_ready` is high again at T+8 (absent `load_valid`).
- **Board visibility:**
  - lane k's result is visible on `board` from cycle T+2+k;
  - the spawned tile is visible from T+7.
- **`busy`:** high T+1..T+7.
- **Row unit:** must be purely combinational; `ru_*_r` is sampled at the end of each Lk cycle.
- **Input sampling:** `move_dir` is sampled only at acceptance. Changing it mid-move has no effect, and `move_valid` during `busy` is ignored (not queued).
- **Reset:** takes effect on the next edge from any state, including mid-move, with no `done`. Reset values:
  - state IDLE;
  - board all zero;
  - `snap` zero;
  - `moved`=0, `done`=0, `busy`=0;
  - `board_full`=0;
  - `move_ready`=1 (when `load_valid`=0);
  - lfsr=LFSR_SEED.
- **Boundary cases:**
  - all-zero board with a move: `chg`=0, no spawn, `moved`=0;
  - full board with `chg`=1 is impossible without a merge; if a merge occurred, a zero exists;
  - the scan wraps from index 15 to 0.

## Test plan
- Load row 0 = [2,2,4,0] (c=0..3), rest 0; move left with a golden row model → row 0 = [4,4,0,0] plus one spawned tile (2 or 4) in a previously-zero cell; `moved`=1; `done` exactly 7 cycles after acceptance.
- Load a board with no possible left move (every row e.g. [2,4,8,16]); move left → board bit-identical to the load, `moved`=0, no spawn, `board_full`=1.
- Up move with column 1 = [2,2,2,2] (r=0..3) → column 1 = [4,4,0,0]. Down move on the same load → column 1 = [0,0,4,4]. Check that `ru_d` is (0,1) and (3,1) respectively during L1.
- Force lfsr so that `lfsr[3:0]`=15 at SPN, with cell 15 nonzero and cell 0 zero → spawn lands in cell 0 (wrap). With `lfsr[7:4]`=F → value 4.
- Assert `rst` during L2 → next cycle: state IDLE, board all zero, `done` never pulses, `move_ready`=1.
- Assert `load_valid` and `move_valid` in the same IDLE cycle → load applied, move not accepted, `busy` stays 0; `move_valid` during `busy` → ignored, exactly one `done`.
